cbfp1_seq_ctrl: RTL and testbench
=================================

CBFP1_SEQ_CTRL -- requirements
Module: cbfp1_seq_ctrl

Interface
REQ-001 Parameter NCHAN, default 16: samples per beat presented to cbfp1_module; informational only.
REQ-002 Parameter BEATS, default 32: beats per frame (512-point frame / 16).
REQ-003 Parameter FRM_W, default 8: width of frame-count fields.
REQ-004 Parameter INFL_W, default 6: width of in-flight beat counter; SHALL hold the maximum cbfp1 latency in beats.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: one-cycle pulse that arms a run; honoured in IDLE only.
REQ-008 Port frames_req, input, FRM_W: frames to process; sampled on start; 0 means continuous until abort.
REQ-009 Port abort, input, 1: pulse that stops the run after the current frame.
REQ-010 Port up_valid, input, 1: upstream beat valid.
REQ-011 Port cbfp_valid_in, output, 1: drives cbfp1_module valid_in.
REQ-012 Port cbfp_valid_out, input, 1: cbfp1_module valid_out.
REQ-013 Port beat_idx, output, $clog2(BEATS): index of the current output beat within its frame.
REQ-014 Port sof / eof, output, 1 each: first and last output beat of a frame.
REQ-015 Port frame_cnt, output, FRM_W: frames completed at the output.
REQ-016 Port busy, output, 1: high in any state other than IDLE.
REQ-017 Port done, output, 1: one-cycle completion pulse.
REQ-018 Port err_gap, output, 1: sticky flag for an upstream gap inside a frame.

Function
REQ-019 FSM states SHALL be IDLE, ARMED, RUN, DRAIN and DONE.
REQ-020 IDLE→ARMED on start; frames_req is latched and err_gap, frame_cnt and all counters are cleared.
REQ-021 ARMED→RUN on the first up_valid; that beat SHALL be in-beat 0.
REQ-022 cbfp_valid_in SHALL equal up_valid in ARMED and RUN, and 0 otherwise (combinational, zero latency).
REQ-023 The in-beat counter SHALL increment on each cbfp_valid_in and wrap BEATS-1→0; each wrap increments the in-frame count.
REQ-024 RUN→DRAIN SHALL occur on the accepted last beat (in-beat BEATS-1) when the in-frame count+1 equals a non-zero frames_req, or when abort is pending.
REQ-025 An abort received in ARMED SHALL go directly to DRAIN.
REQ-026 An abort received in RUN SHALL be held pending until that frame's last beat.
REQ-027 In RUN with in-beat ≠ 0 and up_valid=0, err_gap SHALL set; the counters hold and the frame continues when valid resumes.
REQ-028 The in-flight counter SHALL apply +1 on cbfp_valid_in and −1 on cbfp_valid_out; simultaneous events leave it unchanged.
REQ-029 cbfp_valid_out with in-flight=0 SHALL set err_gap and SHALL NOT decrement the in-flight counter.
REQ-030 The out-beat counter SHALL advance on cbfp_valid_out and wrap at BEATS-1; each wrap increments frame_cnt, which wraps modulo 2^FRM_W.
REQ-031 beat_idx SHALL equal the out-beat counter.
REQ-032 sof = cbfp_valid_out & (out-beat==0); eof = cbfp_valid_out & (out-beat==BEATS-1); both combinational and aligned with cbfp1 outputs.
REQ-033 DRAIN→DONE SHALL occur when in-flight=0 and cbfp_valid_out=0.
REQ-034 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-035 start outside IDLE SHALL be ignored.

Reset
REQ-036 rst SHALL force IDLE with all counters 0, err_gap=0, done=0, busy=0, cbfp_valid_in=0 and abort-pending cleared.
REQ-037 rst mid-run SHALL discard in-flight bookkeeping; cbfp1_module SHALL be reset from the same rst.

Structure
REQ-038 A shared package SHALL hold the state enum, BEATS and the derived beat-index width.
REQ-039 One sub-module, cbfp1_beat_cnt, SHALL provide the wrap counter with a wrap pulse, instantiated twice (input side and output side).

Verification
REQ-040 Two-frame run: frames_req=2, continuous up_valid, cbfp1 latency 3 → 64 cbfp_valid_in pulses; sof at output beats 0 and 32; eof at 31 and 63; frame_cnt=2; done 1 cycle after the last output beat; err_gap=0.
REQ-041 Gap: up_valid low 2 cycles at in-beat 10 → err_gap=1 (sticky), frame completes with 32 beats, eof on the 32nd output beat.
REQ-042 Abort at in-beat 5 with frames_req=0 → input stops after in-beat 31, in-flight drains to 0, done pulses, frame_cnt=1.
REQ-043 Reset at in-beat 20 → next cycle state IDLE, busy=0, cbfp_valid_in=0 despite up_valid=1.
REQ-044 start while busy plus a spurious cbfp_valid_out in IDLE → start ignored; err_gap=1, in-flight stays 0.
REQ-045 Wrap: FRM_W=2, frames_req=0, 5 frames then abort → frame_cnt=1.

Source files
------------

// File: rtl/cbfp1_seq_ctrl_pkg.sv
// cbfp1_seq_ctrl_pkg: shared state encoding and frame geometry for the cbfp1 sequencer.
package cbfp1_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int BEATS  = 32;
    localparam int BEAT_W = $clog2(BEATS);

endpackage

// File: rtl/cbfp1_seq_ctrl_if.sv
// cbfp1_seq_ctrl_if: control, upstream and cbfp1-side handshake bundle of the sequencer.
interface cbfp1_seq_ctrl_if #(
    parameter int FRM_W = 8,
    parameter int BEATS = cbfp1_seq_ctrl_pkg::BEATS
);
    localparam int BW = $clog2(BEATS);

    logic             start;
    logic [FRM_W-1:0] frames_req;
    logic             abort;
    logic             up_valid;
    logic             cbfp_valid_in;
    logic             cbfp_valid_out;
    logic [BW-1:0]    beat_idx;
    logic             sof;
    logic             eof;
    logic [FRM_W-1:0] frame_cnt;
    logic             busy;
    logic             done;
    logic             err_gap;

    modport master (
        output start, frames_req, abort, up_valid, cbfp_valid_out,
        input  cbfp_valid_in, beat_idx, sof, eof, frame_cnt, busy, done, err_gap
    );

    modport slave (
        input  start, frames_req, abort, up_valid, cbfp_valid_out,
        output cbfp_valid_in, beat_idx, sof, eof, frame_cnt, busy, done, err_gap
    );

endinterface

// File: rtl/cbfp1_beat_cnt.sv
// cbfp1_beat_cnt: beat counter 0..BEATS-1 with a same-cycle wrap pulse on the last counted beat.
module cbfp1_beat_cnt #(
    parameter int BEATS = cbfp1_seq_ctrl_pkg::BEATS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [$clog2(BEATS)-1:0] o_cnt,
    output logic                     o_wrap
);
    localparam int W = $clog2(BEATS);

    logic [W-1:0] r_cnt;

    assign o_wrap = i_en & (r_cnt == W'(BEATS - 1));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/cbfp1_seq_ctrl.sv
// cbfp1_seq_ctrl: frame sequencer gating upstream beats into cbfp1 and tracking frames at its output.
module cbfp1_seq_ctrl
    import cbfp1_seq_ctrl_pkg::*;
#(
    parameter int NCHAN  = 16,
    parameter int BEATS  = cbfp1_seq_ctrl_pkg::BEATS,
    parameter int FRM_W  = 8,
    parameter int INFL_W = 6
) (
    input logic                clk,
    input logic                rst,
    cbfp1_seq_ctrl_if.slave    bus
);
    localparam int BW = $clog2(BEATS);

    if (NCHAN < 1 || INFL_W < 1 || FRM_W < 1 || BEATS < 2) begin : g_bad_cfg
        $error("cbfp1_seq_ctrl: invalid parameter set");
    end

    state_t            r_state;
    logic [FRM_W-1:0]  r_frames;
    logic [FRM_W-1:0]  r_in_frm;
    logic [FRM_W-1:0]  r_frame_cnt;
    logic [INFL_W-1:0] r_infl;
    logic              r_abort_pend;
    logic              r_err_gap;
    logic              r_done;

    logic              w_start;
    logic              w_vin;
    logic              w_vout;
    logic              w_in_wrap;
    logic              w_out_wrap;
    logic              w_last;
    logic              w_infl_zero;
    logic              w_gap;
    logic [BW-1:0]     w_in_beat;
    logic [BW-1:0]     w_out_beat;

    assign w_start     = bus.start & (r_state == S_IDLE);
    assign w_vin       = bus.up_valid & ((r_state == S_ARMED) | (r_state == S_RUN));
    assign w_vout      = bus.cbfp_valid_out;
    assign w_infl_zero = (r_infl == '0);
    assign w_gap       = (r_state == S_RUN) & (w_in_beat != '0) & ~bus.up_valid;
    // Last beat of the run: requested frame count reached, or an abort is (or becomes) pending.
    assign w_last      = w_in_wrap & (((r_frames != '0) & (FRM_W'(r_in_frm + 1'b1) == r_frames))
                                      | r_abort_pend | bus.abort);

    cbfp1_beat_cnt #(.BEATS(BEATS)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (w_vin),
        .o_cnt  (w_in_beat),
        .o_wrap (w_in_wrap)
    );

    cbfp1_beat_cnt #(.BEATS(BEATS)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (w_vout),
        .o_cnt  (w_out_beat),
        .o_wrap (w_out_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_frames     <= '0;
            r_in_frm     <= '0;
            r_frame_cnt  <= '0;
            r_infl       <= '0;
            r_abort_pend <= 1'b0;
            r_err_gap    <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_start) begin
            r_state      <= S_ARMED;
            r_frames     <= bus.frames_req;
            r_in_frm     <= '0;
            r_frame_cnt  <= '0;
            r_infl       <= '0;
            r_abort_pend <= 1'b0;
            r_err_gap    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_in_wrap)
                r_in_frm <= r_in_frm + 1'b1;
            if (w_out_wrap)
                r_frame_cnt <= r_frame_cnt + 1'b1;
            // An output beat with nothing in flight is an error, never an underflow.
            r_infl <= r_infl + INFL_W'(w_vin) - INFL_W'(w_vout & ~w_infl_zero);
            if ((w_vout & w_infl_zero) | w_gap)
                r_err_gap <= 1'b1;
            case (r_state)
                S_ARMED: begin
                    if (bus.abort)
                        r_state <= S_DRAIN;
                    else if (bus.up_valid)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state      <= S_DRAIN;
                        r_abort_pend <= 1'b0;
                    end else if (bus.abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_infl_zero && !w_vout) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cbfp_valid_in = w_vin;
    assign bus.beat_idx      = w_out_beat;
    assign bus.sof           = w_vout & (w_out_beat == '0);
    assign bus.eof           = w_out_wrap;
    assign bus.frame_cnt     = r_frame_cnt;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = r_done;
    assign bus.err_gap       = r_err_gap;

endmodule

// File: tb/tb_cbfp1_seq_ctrl.sv
// tb_cbfp1_seq_ctrl: directed bench with a latency-3 cbfp1 valid model; two DUTs (FRM_W 8 and 2).
module tb_cbfp1_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       up_valid = 1'b0;
    logic       tb_vout = 1'b0;
    logic       use_model = 1'b0;
    logic [7:0] frames_req = 8'd0;
    logic [2:0] pipe_a;
    logic [2:0] pipe_b;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cbfp1_seq_ctrl_if #(.FRM_W(8), .BEATS(32)) bus_a ();
    cbfp1_seq_ctrl_if #(.FRM_W(2), .BEATS(32)) bus_b ();

    assign bus_a.start          = start;
    assign bus_a.frames_req     = frames_req;
    assign bus_a.abort          = abort;
    assign bus_a.up_valid       = up_valid;
    assign bus_a.cbfp_valid_out = use_model ? pipe_a[2] : tb_vout;
    assign bus_b.start          = start;
    assign bus_b.frames_req     = frames_req[1:0];
    assign bus_b.abort          = abort;
    assign bus_b.up_valid       = up_valid;
    assign bus_b.cbfp_valid_out = use_model ? pipe_b[2] : tb_vout;

    // cbfp1 stand-in: valid_out is valid_in delayed by three clocks, reset by the same rst.
    always_ff @(posedge clk) begin
        pipe_a <= rst ? 3'b000 : {pipe_a[1:0], bus_a.cbfp_valid_in};
        pipe_b <= rst ? 3'b000 : {pipe_b[1:0], bus_b.cbfp_valid_in};
    end

    cbfp1_seq_ctrl #(.FRM_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    cbfp1_seq_ctrl #(.FRM_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       st;
        logic [7:0] fr;
        logic       uv;
        logic       vo;
        logic       e_vin;
        logic       e_busy;
        logic       e_sof;
        logic       e_eof;
        logic       e_err;
        logic [4:0] e_idx;
    } vec_t;

    vec_t tbl[10];

    int n_vin;
    int n_vout;
    int n_done;
    int last_vout_cyc;
    int done_cyc;
    int sof_q[$];
    int eof_q[$];

    task automatic do_reset(input logic model);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        up_valid = 1'b0;
        tb_vout = 1'b0;
        use_model = model;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one job; up_valid is high except for a two-cycle gap when beat gap_at is due.
    task automatic run(input logic [7:0] fr, input int gap_at, input int abort_at,
                       input int restart_at, input int budget);
        int gap = 0;
        int post = 0;
        bit ab_sent = 0;
        bit rs_sent = 0;
        n_vin = 0; n_vout = 0; n_done = 0; last_vout_cyc = -1; done_cyc = -1;
        sof_q.delete();
        eof_q.delete();
        @(negedge clk);
        start = 1'b1;
        frames_req = fr;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < budget && post < 4; c++) begin
            up_valid = !(n_vin == gap_at && gap < 2);
            if (!up_valid) gap++;
            abort = (n_vin == abort_at) && !ab_sent;
            if (abort) ab_sent = 1;
            start = (n_vin == restart_at) && !rs_sent;
            if (start) begin
                rs_sent = 1;
                frames_req = 8'd0;
            end
            #1;
            if (bus_a.cbfp_valid_in) n_vin++;
            if (bus_a.cbfp_valid_out) begin
                if (bus_a.sof) sof_q.push_back(n_vout);
                if (bus_a.eof) eof_q.push_back(n_vout);
                n_vout++;
                last_vout_cyc = c;
            end
            if (bus_a.done) begin
                n_done++;
                done_cyc = c;
            end
            if (n_done > 0) post++;
            @(negedge clk);
        end
        up_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            st fr   uv vo  vin busy sof eof err idx
        tbl[0] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[2] = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[3] = '{1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[4] = '{1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[5] = '{1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        tbl[6] = '{1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
        tbl[7] = '{1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        tbl[8] = '{1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1};
        tbl[9] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2};

        // Reset state, with up_valid high to show the gate is closed.
        up_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vin", bus_a.cbfp_valid_in, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_err", bus_a.err_gap, 0);
        chk("rst_frame_cnt", bus_a.frame_cnt, 0);
        chk("rst_beat_idx", bus_a.beat_idx, 0);
        do_reset(1'b0);

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st;
            frames_req = tbl[i].fr;
            up_valid = tbl[i].uv;
            tb_vout = tbl[i].vo;
            #1;
            chk($sformatf("tbl%0d_vin", i), bus_a.cbfp_valid_in, tbl[i].e_vin);
            chk($sformatf("tbl%0d_busy", i), bus_a.busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_sof", i), bus_a.sof, tbl[i].e_sof);
            chk($sformatf("tbl%0d_eof", i), bus_a.eof, tbl[i].e_eof);
            chk($sformatf("tbl%0d_err", i), bus_a.err_gap, tbl[i].e_err);
            chk($sformatf("tbl%0d_idx", i), bus_a.beat_idx, tbl[i].e_idx);
            @(negedge clk);
        end

        // Two back-to-back frames, continuous input.
        do_reset(1'b1);
        run(8'd2, -1, -1, -1, 200);
        chk("two_done_cnt", n_done, 1);
        chk("two_vin", n_vin, 64);
        chk("two_vout", n_vout, 64);
        chk("two_sof_n", sof_q.size(), 2);
        chk("two_sof0", sof_q.size() > 0 ? sof_q[0] : -1, 0);
        chk("two_sof1", sof_q.size() > 1 ? sof_q[1] : -1, 32);
        chk("two_eof_n", eof_q.size(), 2);
        chk("two_eof0", eof_q.size() > 0 ? eof_q[0] : -1, 31);
        chk("two_eof1", eof_q.size() > 1 ? eof_q[1] : -1, 63);
        chk("two_frame_cnt", bus_a.frame_cnt, 2);
        chk("two_err", bus_a.err_gap, 0);
        chk("two_busy_end", bus_a.busy, 0);
        chk("two_done_after_out", (done_cyc > last_vout_cyc) && (done_cyc - last_vout_cyc <= 3), 1);

        // Upstream gap of two cycles at in-beat 10.
        do_reset(1'b1);
        run(8'd1, 10, -1, -1, 200);
        chk("gap_done_cnt", n_done, 1);
        chk("gap_vin", n_vin, 32);
        chk("gap_vout", n_vout, 32);
        chk("gap_eof_n", eof_q.size(), 1);
        chk("gap_eof_pos", eof_q.size() > 0 ? eof_q[0] : -1, 31);
        chk("gap_err_sticky", bus_a.err_gap, 1);
        chk("gap_frame_cnt", bus_a.frame_cnt, 1);

        // Abort at in-beat 5 of a continuous run: the frame finishes, then drains.
        do_reset(1'b1);
        run(8'd0, -1, 5, -1, 200);
        chk("abort_done_cnt", n_done, 1);
        chk("abort_vin", n_vin, 32);
        chk("abort_vout", n_vout, 32);
        chk("abort_frame_cnt", bus_a.frame_cnt, 1);
        chk("abort_err", bus_a.err_gap, 0);
        chk("abort_busy_end", bus_a.busy, 0);

        // start while busy must not reload frames_req (0 would make it continuous).
        do_reset(1'b1);
        run(8'd1, -1, -1, 8, 200);
        chk("restart_done_cnt", n_done, 1);
        chk("restart_vin", n_vin, 32);
        chk("restart_frame_cnt", bus_a.frame_cnt, 1);
        chk("spur_err_pre", bus_a.err_gap, 0);
        use_model = 1'b0;
        @(negedge clk);
        tb_vout = 1'b1;
        @(negedge clk);
        tb_vout = 1'b0;
        #1;
        chk("spur_err", bus_a.err_gap, 1);
        chk("spur_infl", dut_a.r_infl, 0);
        chk("spur_busy", bus_a.busy, 0);

        // Five frames then abort: frame_cnt wraps on the 2-bit instance.
        do_reset(1'b1);
        run(8'd0, -1, 4 * 32 + 5, -1, 400);
        chk("wrap_done_cnt", n_done, 1);
        chk("wrap_vin", n_vin, 160);
        chk("wrap_cnt_w8", bus_a.frame_cnt, 5);
        chk("wrap_cnt_w2", bus_b.frame_cnt, 1);
        chk("wrap_busy_w2", bus_b.busy, 0);

        // Reset in the middle of a frame at in-beat 20.
        do_reset(1'b1);
        n_vin = 0;
        @(negedge clk);
        start = 1'b1;
        frames_req = 8'd0;
        up_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && n_vin < 20; c++) begin
            #1;
            if (bus_a.cbfp_valid_in) n_vin++;
            @(negedge clk);
        end
        chk("mrst_reached", n_vin, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_busy", bus_a.busy, 0);
        chk("mrst_vin", bus_a.cbfp_valid_in, 0);
        chk("mrst_idx", bus_a.beat_idx, 0);
        chk("mrst_frame_cnt", bus_a.frame_cnt, 0);
        chk("mrst_infl", dut_a.r_infl, 0);
        @(negedge clk);
        #1;
        chk("mrst_vin_later", bus_a.cbfp_valid_in, 0);
        up_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
